// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: FSM states and write-back select codes.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  localparam logic [1:0] REGSRC_PC  = 2'b00;
  localparam logic [1:0] REGSRC_MEM = 2'b01;
  localparam logic [1:0] REGSRC_ALU = 2'b10;

endpackage

// File: rtl/mem_wb_if.sv
// Request/response handshake between the requester FSM and the data memory.
interface mem_wb_if;

  logic rd;
  logic wr;
  logic done;
  logic stall;

  modport master (output rd, output wr, input done, input stall);
  modport slave  (input rd, input wr, output done, output stall);

endinterface

// File: rtl/mem_req_fsm.sv
// Memory request sequencer: issues/retries the access and reports completion.
module mem_req_fsm
  import mem_wb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memop_i,
  input  logic        aligned_i,
  input  logic        rd_i,
  input  logic        wr_i,
  mem_wb_if.master    bus,
  output logic        stall_o,
  output logic        complete_o
);

  state_t state_q;
  state_t state_d;
  logic   req_act;

  // A request is on the bus for an aligned op seen in IDLE, and on every retry
  assign req_act = ((state_q == ST_IDLE) && memop_i && aligned_i) ||
                   (state_q == ST_REQ);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_REQ: begin
        if (req_act) begin
          if (bus.done)       state_d = ST_IDLE;
          else if (bus.stall) state_d = ST_REQ;
          else                state_d = ST_WAIT;
        end
      end
      ST_WAIT: if (bus.done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: request strobes, upstream stall and completion pulse
  always_comb begin
    bus.rd     = req_act & rd_i;
    bus.wr     = req_act & wr_i;
    stall_o    = (req_act | (state_q == ST_WAIT)) & ~bus.done;
    complete_o = ((req_act | (state_q == ST_WAIT)) & bus.done) |
                 ((state_q == ST_IDLE) & memop_i & ~aligned_i);
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with MEM/WB pipeline register.
module mem_wb_stage
  import mem_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] Addr,
  input  logic [15:0] WriteData,
  input  logic [15:0] PcIn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  RegSrcIn,
  input  logic        FWB_errIn,
  input  logic [15:0] mem_DataOut,
  input  logic        mem_Done,
  input  logic        mem_Stall,
  input  logic        mem_err,
  output logic        mem_Rd,
  output logic        mem_Wr,
  output logic [15:0] mem_Addr,
  output logic [15:0] mem_DataIn,
  output logic        stall_out,
  output logic        wb_valid,
  output logic [15:0] MemOut,
  output logic [15:0] PcOut,
  output logic [15:0] ALUOut,
  output logic [1:0]  RegSrc,
  output logic        FWB_err,
  output logic        DMWB_err
);

  mem_wb_if bus ();

  logic memop;
  logic misaligned;
  logic complete;
  logic load_wb;

  logic        wb_valid_q;
  logic [15:0] mem_out_q, pc_out_q, alu_out_q;
  logic [1:0]  reg_src_q;
  logic        fwb_err_q, dmwb_err_q;

  assign memop      = in_valid & (MemRead | MemWrite);
  assign misaligned = memop & Addr[0];

  assign bus.done   = mem_Done;
  assign bus.stall  = mem_Stall;
  assign mem_Rd     = bus.rd;
  assign mem_Wr     = bus.wr;
  assign mem_Addr   = Addr;
  assign mem_DataIn = WriteData;

  mem_req_fsm u_fsm (
    .clk_i      (clk),
    .rst_i      (rst),
    .memop_i    (memop),
    .aligned_i  (~Addr[0]),
    .rd_i       (MemRead),
    .wr_i       (MemWrite),
    .bus        (bus),
    .stall_o    (stall_out),
    .complete_o (complete)
  );

  assign load_wb = complete | (in_valid & ~memop);

  // MEM/WB register: load on completion, otherwise bubble with held data
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      mem_out_q  <= '0;
      pc_out_q   <= '0;
      alu_out_q  <= '0;
      reg_src_q  <= REGSRC_PC;
      fwb_err_q  <= 1'b0;
      dmwb_err_q <= 1'b0;
    end else begin
      wb_valid_q <= load_wb;
      if (load_wb) begin
        if (MemRead) mem_out_q <= mem_DataOut;
        pc_out_q   <= PcIn;
        alu_out_q  <= Addr;
        reg_src_q  <= RegSrcIn;
        fwb_err_q  <= FWB_errIn;
        dmwb_err_q <= mem_err | misaligned | (MemRead & MemWrite);
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign MemOut   = mem_out_q;
  assign PcOut    = pc_out_q;
  assign ALUOut   = alu_out_q;
  assign RegSrc   = reg_src_q;
  assign FWB_err  = fwb_err_q;
  assign DMWB_err = dmwb_err_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Ports SHALL be, in order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM holds a valid instruction
- Addr  in  16  ALU result / data address
- WriteData  in  16  store data
- PcIn  in  16  PC+2 for link
- MemRead  in  1  load
- MemWrite  in  1  store
- RegSrcIn  in  2  WB select (00 PC, 01 MEM, 1x ALU)
- FWB_errIn  in  1  upstream fetch error
- mem_DataOut  in  16  memory read data
- mem_Done  in  1  memory access complete this cycle
- mem_Stall  in  1  memory rejected the request this cycle
- mem_err  in  1  memory error
- mem_Rd  out  1  read request
- mem_Wr  out  1  write request
- mem_Addr  out  16  request address
- mem_DataIn  out  16  request write data
- stall_out  out  1  hold upstream stages
- wb_valid  out  1  MEM/WB register valid
- MemOut, PcOut, ALUOut  out  16 each  registered WB operands
- RegSrc  out  2  registered WB select
- FWB_err, DMWB_err  out  1 each  registered error flags

Function
REQ-003 Memory op: in_valid & (MemRead | MemWrite); MemRead and MemWrite both set SHALL be treated as a memory op and flagged as DMWB_err.
REQ-004 Misaligned: memory op with Addr[0]=1; no request is issued, completion occurs in the same cycle, DMWB_err=1.
REQ-005 FSM states: IDLE, REQ (request rejected, retry), WAIT (request accepted, awaiting mem_Done).
REQ-006 mem_Rd/mem_Wr SHALL be asserted only in IDLE with an aligned memory op, and in REQ; mem_Addr=Addr, mem_DataIn=WriteData.
REQ-007 IDLE/REQ with request driven: mem_Done -> complete, go IDLE; else mem_Stall -> REQ; else -> WAIT.
REQ-008 WAIT: no request driven; mem_Done -> complete, go IDLE; else stay in WAIT.
REQ-009 stall_out SHALL equal (aligned memory op in IDLE, or state REQ/WAIT) & ~mem_Done, computed combinationally.
REQ-010 Upstream SHALL hold all inputs stable while stall_out=1; the block does not re-sample them.
REQ-011 On the completion edge, or any edge with in_valid & ~memop, the output register SHALL load: MemOut=mem_DataOut (loads only, else hold), PcOut=PcIn, ALUOut=Addr, RegSrc=RegSrcIn, FWB_err=FWB_errIn, DMWB_err=mem_err|misaligned|(Rd&Wr), wb_valid=1.
REQ-012 On any other edge, wb_valid SHALL be 0 (bubble) and the data outputs SHALL hold.
REQ-013 Zero-wait access (mem_Done in the issue cycle) SHALL produce 1-cycle latency with no stall; a non-memory instruction SHALL also have 1-cycle latency.
REQ-014 mem_Done in IDLE without a request SHALL be ignored.

Reset
REQ-015 On rst at a clock edge: state=IDLE, wb_valid=0, all data outputs=0, RegSrc=2'b00, error flags=0; rst overrides any completion in that cycle.
REQ-016 rst mid-access SHALL abandon the outstanding request; a later mem_Done SHALL be ignored per REQ-014.

Structure
REQ-017 Shared package mem_wb_pkg SHALL hold the FSM state encoding and the RegSrc codes (PC=00, MEM=01, ALU=10).
REQ-018 The FSM SHALL be a sub-module mem_req_fsm (state, mem_Rd/mem_Wr, stall_out, complete); mem_wb_stage holds the pipeline register.

Verification
REQ-019 ALU op: RegSrcIn=10, Addr=0x1234 -> next cycle wb_valid=1, ALUOut=0x1234, no mem_Rd.
REQ-020 Zero-wait load: Addr=0x0040, mem_Done=1 with mem_DataOut=0xBEEF in the same cycle -> stall_out=0, next cycle MemOut=0xBEEF.
REQ-021 Rejected store: mem_Stall=1 for 2 cycles, then accepted, mem_Done 3 cycles later -> mem_Wr high 3 cycles, stall_out high 5 cycles, then a single wb_valid pulse.
REQ-022 Misaligned load: Addr=0x0041 -> no mem_Rd, next cycle DMWB_err=1, wb_valid=1.
REQ-023 rst asserted while in WAIT, then mem_Done=1 -> state IDLE, wb_valid stays 0, outputs zero.
REQ-024 mem_err=1 together with mem_Done on a load -> DMWB_err=1; FWB_errIn=1 passes through to FWB_err.
